row_accumulate: RTL and testbench
=================================

ROW_ACCUMULATE -- requirements
Module: row_accumulate

Interface
- REQ-001: Parameter BITS_ROW_IDX, default `BITS_ROW_IDX, row-index field width.
- REQ-002: Parameter BITS_VAL, default 32, value field width, unsigned integer.
- REQ-003: Clocking is fixed: one clock; reset is asynchronous and active-low.
- REQ-004: clk  input  1  sole clock, all state updates on rising edge.
- REQ-005: rst_b  input  1  asynchronous active-low reset.
- REQ-006: in_valid  input  1  upstream entry present; this is the merged output of the 2-input compare/select merge stage.
- REQ-007: in_ready  output  1  block accepts the entry this cycle.
- REQ-008: in_row  input  BITS_ROW_IDX  row index; non-decreasing within a stream.
- REQ-009: in_val  input  BITS_VAL  partial product value.
- REQ-010: in_last  input  1  final entry of the current stream.
- REQ-011: out_valid  output  1  reduced entry present.
- REQ-012: out_ready  input  1  downstream accepts the output entry.
- REQ-013: out_row  output  BITS_ROW_IDX  row index of reduced entry.
- REQ-014: out_val  output  BITS_VAL  sum of all accepted values with that row index.
- REQ-015: out_last  output  1  entry is the final one of the stream.
- REQ-016: err_order  output  1  sticky flag: row-order violation seen.

Function
- REQ-017: An input transfer occurs on a rising edge where in_valid && in_ready; an output transfer occurs where out_valid && out_ready.
- REQ-018: Internal state: accumulator (acc_row, acc_val, acc_vld), one-entry output register (out_*), FSM {EMPTY, ACC, FLUSH}.
- REQ-019: in_ready is (!out_valid || out_ready) in EMPTY and ACC, and 0 in FLUSH.
- REQ-020: EMPTY, transfer, in_last=0: acc loads in_row/in_val, acc_vld=1, go ACC; no output is loaded.
- REQ-021: ACC, transfer, in_row == acc_row: acc_val <= acc_val + in_val, modulo 2^BITS_VAL; carry is discarded; no output is loaded.
- REQ-022: ACC, transfer, in_row > acc_row: output register loads {acc_row, acc_val, last=0} and acc loads the new entry, in the same edge.
- REQ-023: ACC, transfer, in_row < acc_row: err_order sets; the entry is handled as in REQ-022 (emit old, load new).
- REQ-024: Any transfer with in_last=1: the accumulator update follows REQ-020..023; the state then goes to FLUSH.
- REQ-025: FLUSH: on the first edge where (!out_valid || out_ready), the output register loads {acc_row, acc_val, last=1}, acc_vld clears, and the state goes to EMPTY.
- REQ-026: Latency: a row's sum becomes visible (out_valid=1) on the cycle after the edge that accepts the first entry of the next row, or after the FLUSH load.
- REQ-027: If the output register is unloaded and not reloaded on the same edge, out_valid clears; out_* data holds its last value.
- REQ-028: A single-entry stream (EMPTY, in_last=1) yields exactly one output, with out_last=1, one cycle after FLUSH is entered, given out_ready=1.
- REQ-029: With out_ready held high and no row change, in_ready stays 1, giving sustained throughput of 1 entry/cycle.
- REQ-030: The output register is never overwritten while out_valid && !out_ready.

Reset
- REQ-031: While rst_b=0: state=EMPTY, acc_vld=0, out_valid=0, out_last=0, err_order=0; in_ready=1 after release; acc/out data are 0.
- REQ-032: Reset asserted mid-stream discards the accumulator and any pending output with no output transfer; the first post-reset entry starts a new stream.
- REQ-033: err_order clears only on reset.

Verification
- REQ-034: Stream (3,5),(3,7),(4,1,last), out_ready=1 -> outputs (3,12,last=0), then (4,1,last=1); err_order=0.
- REQ-035: BITS_VAL=8, entries (2,200),(2,100,last) -> one output (2,44,last=1).
- REQ-036: Same as REQ-034 with out_ready=0 for 5 cycles after the first output -> in_ready=0 during the stall, output (3,12) held stable, no loss or duplication after release.
- REQ-037: Entries (9,1),(6,2,last) -> err_order=1 after the second transfer; outputs (9,1,0),(6,2,1); err_order stays 1 until reset.
- REQ-038: rst_b pulsed low while acc holds (5,10) and out_valid=1 -> out_valid=0 immediately; next stream (1,1,last) -> single output (1,1,1).
- REQ-039: Random sorted streams with random out_ready -> output sums match a reference model per row; exactly one out_last per stream.

Source files
------------

// File: rtl/row_accumulate.sv
// Row-wise reduction of a sorted (row, value) stream: consecutive entries that share a
// row index are summed, and each completed row is emitted through a one-entry output register.
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif

module row_accumulate #(
  parameter int BITS_ROW_IDX = `BITS_ROW_IDX,
  parameter int BITS_VAL     = 32
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITS_ROW_IDX-1:0] in_row,
  input  logic [BITS_VAL-1:0]     in_val,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITS_ROW_IDX-1:0] out_row,
  output logic [BITS_VAL-1:0]     out_val,
  output logic                    out_last,
  output logic                    err_order
);

  typedef enum logic [1:0] {EMPTY, ACC, FLUSH} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [BITS_ROW_IDX-1:0] acc_row;
  logic [BITS_VAL-1:0]     acc_val;
  logic                    acc_vld;

  logic out_free;
  logic take;
  logic acc_hit;
  logic emit_row;
  logic emit_flush;
  logic row_back;

  // Sums wrap modulo 2^BITS_VAL; the carry out is intentionally dropped.
  function automatic logic [BITS_VAL-1:0] wrap_add(input logic [BITS_VAL-1:0] a,
                                                   input logic [BITS_VAL-1:0] b);
    return a + b;
  endfunction

  assign out_free   = !out_valid || out_ready;
  assign take       = in_valid && in_ready;
  assign acc_hit    = acc_vld && (in_row == acc_row);
  assign emit_row   = (state == ACC) && take && !acc_hit;
  assign row_back   = (state == ACC) && take && acc_vld && (in_row < acc_row);
  assign emit_flush = (state == FLUSH) && out_free;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (take) state_nxt = in_last ? FLUSH : ACC;
      ACC:     if (take && in_last) state_nxt = FLUSH;
      FLUSH:   if (out_free) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    in_ready = (state != FLUSH) && out_free;
  end

  // Accumulator: merge same-row entries, restart on a row change or from empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_row <= '0;
      acc_val <= '0;
      acc_vld <= 1'b0;
    end else if (take) begin
      acc_vld <= 1'b1;
      if ((state == ACC) && acc_hit) begin
        acc_val <= wrap_add(acc_val, in_val);
      end else begin
        acc_row <= in_row;
        acc_val <= in_val;
      end
    end else if (emit_flush) begin
      acc_vld <= 1'b0;
    end
  end

  // Output register: loads only when free, so a stalled entry is never overwritten.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_val   <= '0;
      out_last  <= 1'b0;
    end else if (emit_row || emit_flush) begin
      out_valid <= 1'b1;
      out_row   <= acc_row;
      out_val   <= acc_val;
      out_last  <= emit_flush;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)        err_order <= 1'b0;
    else if (row_back) err_order <= 1'b1;
  end

endmodule

// File: tb/tb_row_accumulate.sv
// Bench for row_accumulate: directed streams plus random sorted streams against a
// group-and-sum reference model.
module tb_row_accumulate;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_row;
  logic [7:0] in_val;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_row;
  logic [7:0] out_val;
  logic       out_last;
  logic       err_order;

  typedef struct {
    logic [7:0] row;
    logic [7:0] val;
    logic       last;
  } ent_t;

  ent_t got[$];
  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_stalls;
  bit   rand_mode = 1'b0;

  row_accumulate #(.BITS_ROW_IDX(8), .BITS_VAL(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_val(in_val),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_val(out_val),
    .out_last(out_last), .err_order(err_order)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_b && out_valid && out_ready) got.push_back('{out_row, out_val, out_last});

  initial begin
    forever begin
      @(negedge clk);
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] v, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_row = r; in_val = v; in_last = l;
    while (!done) begin
      #1 done = in_ready;
      @(posedge clk);
      if (!done) begin
        n++;
        if (n > 300) begin
          chk("send_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    #1 in_valid = 1'b0;
    last_stalls = n;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk("out_count", got.size(), n);
  endtask

  task automatic chk_ent(input string tag, input int i, input ent_t e);
    if (i < got.size()) begin
      chk({tag, "_row"}, got[i].row, e.row);
      chk({tag, "_val"}, got[i].val, e.val);
      chk({tag, "_last"}, got[i].last, e.last);
    end else begin
      chk({tag, "_missing"}, got.size(), i + 1);
    end
  endtask

  initial begin
    rst_b = 1'b0; in_valid = 1'b0; in_row = '0; in_val = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err_order, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_val", out_val, 0);
    rst_b = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // basic stream with row change and last
    got.delete();
    send(8'd3, 8'd5, 1'b0);
    send(8'd3, 8'd7, 1'b0);
    chk("throughput_stalls", last_stalls, 0);
    send(8'd4, 8'd1, 1'b1);
    wait_out(2);
    chk_ent("s1_0", 0, '{8'd3, 8'd12, 1'b0});
    chk_ent("s1_1", 1, '{8'd4, 8'd1, 1'b1});
    chk("s1_err", err_order, 0);

    // modulo wrap: 200 + 100 = 300 -> 44
    got.delete();
    send(8'd2, 8'd200, 1'b0);
    send(8'd2, 8'd100, 1'b1);
    wait_out(1);
    chk_ent("wrap", 0, '{8'd2, 8'd44, 1'b1});

    // output stall for 5 cycles after the first output
    got.delete();
    send(8'd3, 8'd5, 1'b0);
    send(8'd3, 8'd7, 1'b0);
    out_ready = 1'b0;
    send(8'd4, 8'd1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_row", out_row, 3);
      chk("stall_out_val", out_val, 12);
    end
    out_ready = 1'b1;
    wait_out(2);
    chk_ent("stall_0", 0, '{8'd3, 8'd12, 1'b0});
    chk_ent("stall_1", 1, '{8'd4, 8'd1, 1'b1});

    // row order violation, sticky flag
    got.delete();
    send(8'd9, 8'd1, 1'b0);
    chk("order_err_before", err_order, 0);
    send(8'd6, 8'd2, 1'b1);
    chk("order_err_set", err_order, 1);
    wait_out(2);
    chk_ent("order_0", 0, '{8'd9, 8'd1, 1'b0});
    chk_ent("order_1", 1, '{8'd6, 8'd2, 1'b1});
    got.delete();
    send(8'd7, 8'd7, 1'b1);
    wait_out(1);
    chk("order_err_sticky", err_order, 1);

    // reset mid-stream with a pending output
    got.delete();
    out_ready = 1'b0;
    send(8'd2, 8'd3, 1'b0);
    send(8'd5, 8'd10, 1'b0);
    chk("mid_pending", out_valid, 1);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err", err_order, 0);
    chk("mid_rst_out_val", out_val, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    out_ready = 1'b1;
    #1 chk("mid_in_ready", in_ready, 1);
    chk("mid_no_xfer", got.size(), 0);
    send(8'd1, 8'd1, 1'b1);
    chk("single_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    chk("single_visible", out_valid, 1);
    chk("single_last", out_last, 1);
    wait_out(1);
    chk_ent("single", 0, '{8'd1, 8'd1, 1'b1});

    // random sorted streams with random back-pressure
    rand_mode = 1'b1;
    for (int s = 0; s < 30; s++) begin : rnd
      int len;
      int r;
      int v;
      int lasts;
      got.delete();
      exp_q.delete();
      len = $urandom_range(1, 12);
      r   = $urandom_range(0, 200);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 1) == 1) r = r + $urandom_range(1, 2);
        v = $urandom_range(0, 255);
        if (exp_q.size() == 0 || exp_q[exp_q.size()-1].row != 8'(r))
          exp_q.push_back('{8'(r), 8'(v), 1'b0});
        else
          exp_q[exp_q.size()-1].val = 8'(exp_q[exp_q.size()-1].val + 8'(v));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(8'(r), 8'(v), (i == len - 1));
      end
      exp_q[exp_q.size()-1].last = 1'b1;
      wait_out(exp_q.size());
      lasts = 0;
      foreach (got[k]) if (got[k].last) lasts++;
      chk("rnd_one_last", lasts, 1);
      foreach (exp_q[k]) chk_ent("rnd", k, exp_q[k]);
    end
    chk("rnd_err", err_order, 0);
    rand_mode = 1'b0;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
